// File: rtl/tlp_dispatch_pkg.sv
// rtl/tlp_dispatch_pkg.sv - shared encodings and sizes for the TLP grant dispatcher
package tlp_dispatch_pkg;

    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;
    localparam int CRED_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } disp_state_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [ID_W-1:0] id, input logic en);
        ch_onehot = en ? (NUM_CH'(1) << id) : '0;
    endfunction

endpackage

// File: rtl/tlp_credit_counter.sv
// rtl/tlp_credit_counter.sv - downstream credit count with saturation and sticky overflow flag
module tlp_credit_counter
    import tlp_dispatch_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec,
    input  logic              inc,
    output logic [CRED_W-1:0] count,
    output logic              zero_next,
    output logic              ovf
);

    localparam logic [CRED_W-1:0] FULL = CRED_W'(CREDITS);

    logic [CRED_W-1:0] r_count;
    logic [CRED_W-1:0] w_count_nxt;
    logic              r_ovf;
    logic              w_sat_hit;

    // A simultaneous consume and return cancel out; a return at full is dropped and flagged.
    always_comb begin
        w_count_nxt = r_count;
        w_sat_hit   = 1'b0;
        if (dec && !inc) begin
            w_count_nxt = r_count - CRED_W'(1);
        end else if (inc && !dec) begin
            if (r_count == FULL) begin
                w_sat_hit = 1'b1;
            end else begin
                w_count_nxt = r_count + CRED_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= FULL;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_sat_hit) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign count     = r_count;
    assign zero_next = (w_count_nxt == '0);
    assign ovf       = r_ovf;

endmodule

// File: rtl/tlp_grant_dispatcher.sv
// rtl/tlp_grant_dispatcher.sv - pops the arbiter-granted channel FIFO and forwards its head word under credit control
// Optional per-channel fire counters: TLP_DISPATCH_STATS_EN
module tlp_grant_dispatcher
    import tlp_dispatch_pkg::*;
#(
    parameter int DATA_W  = 10,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [ID_W-1:0]   out_id,
    input  logic              empty0,
    input  logic              empty1,
    input  logic              empty2,
    input  logic              empty3,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    input  logic              credit_ret,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [ID_W-1:0]   id_out,
    output logic [CRED_W-1:0] credits,
    output logic              err_ovf
`ifdef TLP_DISPATCH_STATS_EN
    ,
    output logic [7:0]        cnt0,
    output logic [7:0]        cnt1,
    output logic [7:0]        cnt2,
    output logic [7:0]        cnt3
`endif
);

    if (CREDITS < 1 || CREDITS > 15) begin : g_bad_credits
        $error("CREDITS must be in 1..15");
    end

    disp_state_t       r_state;
    logic              r_valid_out;
    logic [DATA_W-1:0] r_data_out;
    logic [ID_W-1:0]   r_id_out;

    logic [NUM_CH-1:0] w_empty;
    logic [DATA_W-1:0] w_data [NUM_CH];
    logic [NUM_CH-1:0] w_pop;
    logic [CRED_W-1:0] w_credits;
    logic              w_zero_next;
    logic              w_ovf;
    logic              w_fire;

    assign w_empty   = {empty3, empty2, empty1, empty0};
    assign w_data[0] = data0;
    assign w_data[1] = data1;
    assign w_data[2] = data2;
    assign w_data[3] = data3;

    // Gating by reset here keeps the FIFOs untouched in the cycle reset is sampled.
    assign w_fire = !reset && (r_state == ST_RUN) && valid
                    && !w_empty[out_id] && (w_credits != '0);
    assign w_pop  = ch_onehot(out_id, w_fire);

    assign pop0 = w_pop[0];
    assign pop1 = w_pop[1];
    assign pop2 = w_pop[2];
    assign pop3 = w_pop[3];

    tlp_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk       (clk),
        .reset     (reset),
        .dec       (w_fire),
        .inc       (credit_ret),
        .count     (w_credits),
        .zero_next (w_zero_next),
        .ovf       (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_id_out    <= '0;
        end else begin
            r_valid_out <= w_fire;
            if (w_fire) begin
                r_data_out <= w_data[out_id];
                r_id_out   <= out_id;
            end
            case (r_state)
                ST_IDLE:  r_state <= ST_RUN;
                ST_RUN:   if (w_zero_next) r_state <= ST_STALL;
                ST_STALL: if (w_credits != '0) r_state <= ST_RUN;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign id_out    = r_id_out;
    assign credits   = w_credits;
    assign err_ovf   = w_ovf;

`ifdef TLP_DISPATCH_STATS_EN
    logic [7:0] r_cnt [NUM_CH];

    // Counters wrap naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
    assign cnt3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_tlp_grant_dispatcher.sv
// tb/tb_tlp_grant_dispatcher.sv - scoreboard bench for tlp_grant_dispatcher (optional stats via TLP_DISPATCH_STATS_EN)
module tb_tlp_grant_dispatcher;

    typedef struct {
        int         cyc;
        logic [9:0] data;
        logic [1:0] id;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [1:0] out_id;
    logic [3:0] empty;
    logic [9:0] data [4];
    logic       credit_ret;
    logic       pop0, pop1, pop2, pop3;
    logic [9:0] data_out;
    logic       valid_out;
    logic [1:0] id_out;
    logic [3:0] credits;
    logic       err_ovf;
`ifdef TLP_DISPATCH_STATS_EN
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif

    wire [3:0] pops = {pop3, pop2, pop1, pop0};

    int   n_cmp;
    int   n_err;
    int   cyc;
    exp_t sb[$];

    tlp_grant_dispatcher #(.DATA_W(10), .CREDITS(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .out_id(out_id),
        .empty0(empty[0]), .empty1(empty[1]), .empty2(empty[2]), .empty3(empty[3]),
        .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
        .credit_ret(credit_ret),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .data_out(data_out), .valid_out(valid_out), .id_out(id_out),
        .credits(credits), .err_ovf(err_ovf)
`ifdef TLP_DISPATCH_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL sb_missing: word 0x%0h id %0d due at cycle %0d never seen", e.data, e.id, e.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (valid_out !== 1'b1 || data_out !== e.data || id_out !== e.id) begin
                n_err++;
                $display("FAIL sb_word: got v=%b data=0x%0h id=%0d, want v=1 data=0x%0h id=%0d",
                         valid_out, data_out, id_out, e.data, e.id);
            end
        end else if (valid_out === 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: valid_out=1 data=0x%0h id=%0d with nothing expected", data_out, id_out);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] ch);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = data[ch];
        e.id   = ch;
        sb.push_back(e);
    endtask

    task automatic do_reset;
        valid      = 1'b0;
        credit_ret = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; valid = 1'b1; out_id = 2'd1; empty = 4'b0000; credit_ret = 1'b0;
        for (int i = 0; i < 4; i++) data[i] = 10'(i + 1);
        tick();
        tick();
        n_cmp++; if (pops !== 4'b0000) begin n_err++; $display("FAIL reset_pops: got %b want 0000", pops); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (data_out !== 10'h0) begin n_err++; $display("FAIL reset_data_out: got 0x%0h want 0", data_out); end
        n_cmp++; if (id_out !== 2'd0) begin n_err++; $display("FAIL reset_id_out: got %0d want 0", id_out); end
        n_cmp++; if (credits !== 4'd4) begin n_err++; $display("FAIL reset_credits: got %0d want 4", credits); end
        n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL reset_err_ovf: got %b want 0", err_ovf); end
        valid = 1'b0;
    endtask

    task automatic test_first_grant;
        valid = 1'b1; out_id = 2'd2; empty = 4'b0000; data[2] = 10'h155;
        reset = 1'b0;
        #1;
        n_cmp++; if (pops !== 4'b0000) begin n_err++; $display("FAIL idle_no_pop: got %b want 0000", pops); end
        tick();
        n_cmp++; if (pops !== 4'b0100) begin n_err++; $display("FAIL first_pop2: got %b want 0100", pops); end
        push_exp(2'd2);
        tick();
        valid = 1'b0;
        n_cmp++; if (credits !== 4'd3) begin n_err++; $display("FAIL first_credits: got %0d want 3", credits); end
        tick();
    endtask

    task automatic test_credit_stall;
        int npop;
        do_reset();
        valid = 1'b1; out_id = 2'd0; empty = 4'b0000;
        tick();
        npop = 0;
        for (int i = 0; i < 7; i++) begin
            data[0] = 10'h200 + 10'(i);
            #1;
            if (pops[0] === 1'b1) begin
                npop++;
                push_exp(2'd0);
            end
            tick();
        end
        n_cmp++; if (npop !== 4) begin n_err++; $display("FAIL stall_pop_count: got %0d want 4", npop); end
        n_cmp++; if (credits !== 4'd0) begin n_err++; $display("FAIL stall_credits: got %0d want 0", credits); end
        credit_ret = 1'b1;
        #1;
        n_cmp++; if (pops !== 4'b0000) begin n_err++; $display("FAIL stall_ret_t0: got %b want 0000", pops); end
        tick();
        credit_ret = 1'b0;
        #1;
        n_cmp++; if (pops !== 4'b0000) begin n_err++; $display("FAIL stall_ret_t1: got %b want 0000", pops); end
        n_cmp++; if (credits !== 4'd1) begin n_err++; $display("FAIL stall_ret_credits: got %0d want 1", credits); end
        tick();
        data[0] = 10'h2AA;
        #1;
        n_cmp++; if (pops !== 4'b0001) begin n_err++; $display("FAIL stall_ret_t2: got %b want 0001", pops); end
        push_exp(2'd0);
        tick();
        #1;
        n_cmp++; if (pops !== 4'b0000) begin n_err++; $display("FAIL stall_again: got %b want 0000", pops); end
        n_cmp++; if (credits !== 4'd0) begin n_err++; $display("FAIL stall_again_credits: got %0d want 0", credits); end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_empty_grant;
        do_reset();
        tick();
        valid = 1'b1; out_id = 2'd3; empty = 4'b1000; data[3] = 10'h3C3;
        #1;
        n_cmp++; if (pops !== 4'b0000) begin n_err++; $display("FAIL empty_pop: got %b want 0000", pops); end
        tick();
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL empty_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (credits !== 4'd4) begin n_err++; $display("FAIL empty_credits: got %0d want 4", credits); end
        valid = 1'b0; out_id = 2'd1; empty = 4'b0000;
        #1;
        n_cmp++; if (pops !== 4'b0000) begin n_err++; $display("FAIL novalid_pop: got %b want 0000", pops); end
        tick();
        n_cmp++; if (credits !== 4'd4) begin n_err++; $display("FAIL novalid_credits: got %0d want 4", credits); end
    endtask

    task automatic test_simul_return;
        do_reset();
        tick();
        valid = 1'b1; out_id = 2'd0; empty = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            data[0] = 10'h100 + 10'(i);
            push_exp(2'd0);
            tick();
        end
        n_cmp++; if (credits !== 4'd1) begin n_err++; $display("FAIL simul_pre_credits: got %0d want 1", credits); end
        credit_ret = 1'b1; data[0] = 10'h111;
        #1;
        n_cmp++; if (pops !== 4'b0001) begin n_err++; $display("FAIL simul_pop: got %b want 0001", pops); end
        push_exp(2'd0);
        tick();
        credit_ret = 1'b0; data[0] = 10'h122;
        n_cmp++; if (credits !== 4'd1) begin n_err++; $display("FAIL simul_credits: got %0d want 1", credits); end
        #1;
        n_cmp++; if (pops !== 4'b0001) begin n_err++; $display("FAIL simul_no_stall: got %b want 0001", pops); end
        push_exp(2'd0);
        tick();
        valid = 1'b0;
        n_cmp++; if (credits !== 4'd0) begin n_err++; $display("FAIL simul_end_credits: got %0d want 0", credits); end
        tick();
    endtask

    task automatic test_overflow;
        do_reset();
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        n_cmp++; if (credits !== 4'd4) begin n_err++; $display("FAIL ovf_credits: got %0d want 4", credits); end
        n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", err_ovf); end
        tick();
        tick();
        n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", err_ovf); end
        do_reset();
        n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", err_ovf); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        tick();
        valid = 1'b1; out_id = 2'd1; empty = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            data[1] = 10'h0F0 + 10'(i);
            #1;
            n_cmp++; if (pops !== 4'b0010) begin n_err++; $display("FAIL mid_stream_pop: got %b want 0010", pops); end
            push_exp(2'd1);
            tick();
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (pops !== 4'b0000) begin n_err++; $display("FAIL mid_reset_pop: got %b want 0000", pops); end
        tick();
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (credits !== 4'd4) begin n_err++; $display("FAIL mid_reset_credits: got %0d want 4", credits); end
        valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [1:0] ch;
        logic       emp;
        do_reset();
        tick();
        credit_ret = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ch  = 2'($urandom_range(0, 3));
            emp = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) begin
                data[k]  = 10'($urandom);
                empty[k] = ($urandom_range(0, 1) == 1);
            end
            empty[ch] = emp;
            out_id = ch;
            valid  = 1'b1;
            #1;
            n_cmp++;
            if (pops !== (emp ? 4'b0000 : (4'b0001 << ch))) begin
                n_err++;
                $display("FAIL b2b_pop[%0d]: got %b want %b", i, pops, emp ? 4'b0000 : (4'b0001 << ch));
            end
            if (!emp) push_exp(ch);
            tick();
        end
        valid = 1'b0; credit_ret = 1'b0;
        n_cmp++; if (credits !== 4'd4) begin n_err++; $display("FAIL b2b_credits: got %0d want 4", credits); end
        tick();
    endtask

`ifdef TLP_DISPATCH_STATS_EN
    task automatic test_stats;
        do_reset();
        tick();
        valid = 1'b1; out_id = 2'd0; empty = 4'b0000; credit_ret = 1'b1;
        for (int i = 0; i < 260; i++) begin
            data[0] = 10'(i);
            push_exp(2'd0);
            tick();
        end
        valid = 1'b0; credit_ret = 1'b0;
        tick();
        n_cmp++; if (cnt0 !== 8'd4) begin n_err++; $display("FAIL stats_cnt0: got %0d want 4", cnt0); end
        n_cmp++; if ({cnt1, cnt2, cnt3} !== 24'd0) begin n_err++; $display("FAIL stats_others: got %0d/%0d/%0d want 0", cnt1, cnt2, cnt3); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; valid = 1'b0; out_id = 2'd0; empty = 4'b1111; credit_ret = 1'b0;
        for (int i = 0; i < 4; i++) data[i] = '0;
        test_reset();
        test_first_grant();
        test_credit_stall();
        test_empty_grant();
        test_simul_return();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
`ifdef TLP_DISPATCH_STATS_EN
        test_stats();
`endif
        valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d words left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tlp_grant_dispatcher.md
# tlp_grant_dispatcher

Consumer side of the 4-channel RoundRobin arbiter in the TLP path. Each cycle the arbiter presents a grant (`valid`, `out_id`). This block pops the granted channel FIFO and forwards the head word downstream with a 1-cycle registered latency. Downstream flow control is credit-based: an internal credit counter is decremented per forwarded word and replenished by `credit_ret`.

## Interface
Parameters:
- `DATA_W`, 10, width of one TLP word per channel
- `CREDITS`, 4, downstream credits after reset; range 1..15

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `valid`  in  1  arbiter grant valid
- `out_id`  in  2  arbiter granted channel index
- `empty0..empty3`  in  1 each  channel FIFO empty flags
- `data0..data3`  in  DATA_W each  channel FIFO head words (show-ahead)
- `credit_ret`  in  1  one credit returned by downstream this cycle
- `pop0..pop3`  out  1 each  channel FIFO pop strobes
- `data_out`  out  DATA_W  forwarded word
- `valid_out`  out  1  `data_out` is valid this cycle
- `id_out`  out  2  source channel of `data_out`
- `credits`  out  4  current credit count
- `err_ovf`  out  1  sticky error: credit returned while credits already equal `CREDITS`

## Operation
FSM with states IDLE, RUN, STALL; encodings come from the package.
- IDLE: entered on reset and held for the first cycle after reset deasserts. No pops. Goes to RUN next cycle.
- RUN: `fire = valid && !empty[out_id] && credits != 0`.
  - `pop[out_id] = fire`, combinational, same cycle as the grant. All other pops are 0.
  - Goes to STALL when the next-cycle credit value is 0.
- STALL: no pops. Goes to RUN in the cycle after `credits` becomes nonzero.
- At most one pop asserted in any cycle.
- On the edge after `fire`:
  - `data_out <= data[out_id]`, `id_out <= out_id`, `valid_out <= 1`.
  - Otherwise `valid_out <= 0`; `data_out` and `id_out` hold their last values.
- Credit arithmetic, 4-bit unsigned:
  - `fire && !credit_ret`: decrement.
  - `!fire && credit_ret`: increment.
  - Both: unchanged.
  - Increment at `credits == CREDITS` saturates (no change) and sets `err_ovf`. `err_ovf` clears only on reset.
- Grant on an empty channel: no pop, no credit change, `valid_out` = 0 next cycle. No retry; the arbiter re-grants.
- `valid` = 0: no action, regardless of `out_id`.

## Timing
- Reset values:
  - `pop0..3` = 0, `valid_out` = 0, `data_out` = 0, `id_out` = 0
  - `credits` = `CREDITS`, `err_ovf` = 0, state = IDLE
- Reset asserted mid-operation:
  - Pops are forced to 0 in the same cycle, combinationally gated by `reset`.
  - A word popped in the cycle `reset` is sampled is discarded.
- Grant-to-data latency: 1 cycle. Sustained throughput: 1 word/cycle while credits > 0.
- Credit returned in the cycle credits reach 0 (simultaneous fire and return): the count stays at 1 and the FSM stays in RUN.
- From STALL, a return at cycle t permits a pop at t+2 (t+1 is the STALL→RUN transition).

## Configuration
- `TLP_DISPATCH_STATS_EN` defined:
  - Adds output ports `cnt0..cnt3`, 8 bits each.
  - Each counter increments on every fire of its channel and wraps 255→0.
  - All counters reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `tlp_dispatch_pkg` holds:
  - state encodings `ST_IDLE` = 2'd0, `ST_RUN` = 2'd1, `ST_STALL` = 2'd2
  - `NUM_CH` = 4, `ID_W` = 2, `CRED_W` = 4
- Sub-module `tlp_credit_counter`:
  - Inputs: `clk`, `reset`, `dec`, `inc`.
  - Outputs: `count`, `zero_next`, `ovf`.
  - Parameterised by `CREDITS`.
- Top level contains the FSM, pop decode and output register.

## Test plan
- Reset, then `valid`=1, `out_id`=2, `empty2`=0, `data2`=10'h155 held for the first cycle after reset: no pop in the IDLE cycle. `pop2`=1 in the next cycle; the cycle after, `data_out`=10'h155, `id_out`=2, `valid_out`=1, `credits`=3.
- Continuous grant to ch0 (never empty), no returns, `CREDITS`=4:
  - exactly 4 pops in consecutive cycles, then STALL with `credits`=0
  - one `credit_ret` → exactly one more pop, two cycles later
- Grant ch3 with `empty3`=1: `pop3`=0, `valid_out`=0, `credits` unchanged.
- Fire and `credit_ret` in the same cycle at `credits`=1: `credits` stays 1, no STALL. `credit_ret` at `credits`=4: `credits`=4, `err_ovf`=1 and stays 1 until reset.
- Reset asserted during a stream on ch1: `pop1` drops the same cycle; next cycle `valid_out`=0 and `credits`=4.
- With `TLP_DISPATCH_STATS_EN` defined: 260 fires on ch0 → `cnt0`=4, `cnt1..3`=0.
